instr_fifo_assembler: RTL and testbench

- Front end of the TPU control path.
- Host writes each 80-bit instruction as three beats: lower 32, middle 32, upper 16.
- Block assembles the beats and converts the bits with tpu_pkg::bit_to_instr, then buffers the result in a FIFO.
- Instructions go to the control unit as instr_type over a valid/ready handshake.

---
 rtl/tpu_pkg.sv | 24 ++
 rtl/instr_fifo_assembler_if.sv | 48 ++++
 rtl/instr_fifo_assembler_sync_fifo.sv | 47 ++++
 rtl/instr_fifo_assembler.sv | 80 ++++++++
 tb/tb_instr_fifo_assembler.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/tpu_pkg.sv
// tpu_pkg: shared TPU instruction widths, the decoded instruction type and the bit-to-field converter.
package tpu_pkg;
    localparam int INSTR_WIDTH       = 80;
    localparam int LOWER_WORD_WIDTH  = 32;
    localparam int MIDDLE_WORD_WIDTH = 32;
    localparam int UPPER_WORD_WIDTH  = 16;
    localparam int INSTR_FIFO_DEPTH  = 16;

    typedef struct packed {
        logic [23:0] buffer_addr;
        logic [15:0] acc_addr;
        logic [31:0] length;
        logic [7:0]  opcode;
    } instr_type;

    function automatic instr_type bit_to_instr(input logic [INSTR_WIDTH-1:0] b);
        instr_type r;
        r.opcode      = b[7:0];
        r.length      = b[39:8];
        r.acc_addr    = b[55:40];
        r.buffer_addr = b[79:56];
        return r;
    endfunction
endpackage

// File: rtl/instr_fifo_assembler_if.sv
// instr_fifo_assembler_if: host beat writes, consumer handshake and FIFO status.
// INSTR_FIFO_ERR_EN adds the sticky error flags and their clear.
interface instr_fifo_assembler_if
    import tpu_pkg::*;
#(
    parameter int FIFO_DEPTH = INSTR_FIFO_DEPTH,
    localparam int CNT_WIDTH = $clog2(FIFO_DEPTH) + 1
);
    logic [LOWER_WORD_WIDTH-1:0]  lower_word_i;
    logic [MIDDLE_WORD_WIDTH-1:0] middle_word_i;
    logic [UPPER_WORD_WIDTH-1:0]  upper_word_i;
    logic                         lower_we_i;
    logic                         middle_we_i;
    logic                         upper_we_i;
    instr_type                    instr_o;
    logic                         instr_valid_o;
    logic                         instr_ready_i;
    logic                         full_o;
    logic                         empty_o;
    logic [CNT_WIDTH-1:0]         count_o;
`ifdef INSTR_FIFO_ERR_EN
    logic                         overflow_o;
    logic                         seq_err_o;
    logic                         err_clear_i;

    modport slave (
        input  lower_word_i, middle_word_i, upper_word_i, lower_we_i, middle_we_i, upper_we_i,
        input  instr_ready_i, err_clear_i,
        output instr_o, instr_valid_o, full_o, empty_o, count_o, overflow_o, seq_err_o
    );
    modport master (
        output lower_word_i, middle_word_i, upper_word_i, lower_we_i, middle_we_i, upper_we_i,
        output instr_ready_i, err_clear_i,
        input  instr_o, instr_valid_o, full_o, empty_o, count_o, overflow_o, seq_err_o
    );
`else
    modport slave (
        input  lower_word_i, middle_word_i, upper_word_i, lower_we_i, middle_we_i, upper_we_i,
        input  instr_ready_i,
        output instr_o, instr_valid_o, full_o, empty_o, count_o
    );
    modport master (
        output lower_word_i, middle_word_i, upper_word_i, lower_we_i, middle_we_i, upper_we_i,
        output instr_ready_i,
        input  instr_o, instr_valid_o, full_o, empty_o, count_o
    );
`endif
endinterface

// File: rtl/instr_fifo_assembler_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with occupancy count; a push while full only lands if a pop frees the slot.
module sync_fifo #(
    parameter int WIDTH = 80,
    parameter int DEPTH = 16,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Gated so the head reads zero while nothing valid is stored.
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/instr_fifo_assembler.sv
// instr_fifo_assembler: gathers three host beats into an 80-bit instruction and queues it for the control unit.
// Define INSTR_FIFO_ERR_EN for sticky overflow/sequence-error flags.
module instr_fifo_assembler
    import tpu_pkg::*;
#(
    parameter int FIFO_DEPTH = INSTR_FIFO_DEPTH,
    localparam int CNT_WIDTH = $clog2(FIFO_DEPTH) + 1
) (
    input logic                  clk,
    input logic                  rst_n,
    instr_fifo_assembler_if.slave bus
);
    logic [LOWER_WORD_WIDTH-1:0]  lo_reg;
    logic [MIDDLE_WORD_WIDTH-1:0] mid_reg;
    logic                         lo_vld;
    logic                         mid_vld;
    logic                         lo_set;
    logic                         mid_set;
    logic                         push_req;
    logic                         pop;
    logic [INSTR_WIDTH-1:0]       bits;
    logic [INSTR_WIDTH-1:0]       head;

    // Same-cycle beat writes bypass the holding registers into the commit.
    assign lo_set   = lo_vld || bus.lower_we_i;
    assign mid_set  = mid_vld || bus.middle_we_i;
    assign push_req = bus.upper_we_i && lo_set && mid_set;
    assign bits     = {bus.upper_word_i,
                       bus.middle_we_i ? bus.middle_word_i : mid_reg,
                       bus.lower_we_i ? bus.lower_word_i : lo_reg};
    assign pop      = bus.instr_valid_o && bus.instr_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_reg  <= '0;
            mid_reg <= '0;
            lo_vld  <= 1'b0;
            mid_vld <= 1'b0;
        end else begin
            if (bus.lower_we_i) lo_reg <= bus.lower_word_i;
            if (bus.middle_we_i) mid_reg <= bus.middle_word_i;
            lo_vld  <= !bus.upper_we_i && lo_set;
            mid_vld <= !bus.upper_we_i && mid_set;
        end
    end

    sync_fifo #(.WIDTH(INSTR_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_req),
        .pop   (pop),
        .wdata (bits),
        .rdata (head),
        .full  (bus.full_o),
        .empty (bus.empty_o),
        .count (bus.count_o)
    );

    assign bus.instr_valid_o = !bus.empty_o;
    assign bus.instr_o       = bit_to_instr(head);

`ifdef INSTR_FIFO_ERR_EN
    logic drop;
    logic seq_bad;

    assign drop    = push_req && bus.full_o && !pop;
    assign seq_bad = bus.upper_we_i && !(lo_set && mid_set);

    // A set event in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.overflow_o <= 1'b0;
            bus.seq_err_o  <= 1'b0;
        end else begin
            bus.overflow_o <= drop || (bus.overflow_o && !bus.err_clear_i);
            bus.seq_err_o  <= seq_bad || (bus.seq_err_o && !bus.err_clear_i);
        end
    end
`endif
endmodule

// File: tb/tb_instr_fifo_assembler.sv
// tb_instr_fifo_assembler: directed beats against a queue model of the instruction FIFO, checked every cycle.
// Honours INSTR_FIFO_ERR_EN for the sticky error flags.
module tb_instr_fifo_assembler;
    import tpu_pkg::*;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    instr_fifo_assembler_if #(.FIFO_DEPTH(DEPTH)) bus ();

    instr_fifo_assembler #(.FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of assembled instructions plus the two pending-beat slots.
    logic [79:0] mq[$];
    logic [31:0] m_lo, m_mid, m_l, m_m;
    logic        m_lo_v, m_mid_v, m_pop, m_req, m_drop, m_ov, m_se;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_lo = 0; m_mid = 0; m_lo_v = 0; m_mid_v = 0; m_ov = 0; m_se = 0;
        end else begin
            m_pop  = mq.size() > 0 && bus.instr_ready_i;
            m_l    = bus.lower_we_i ? bus.lower_word_i : m_lo;
            m_m    = bus.middle_we_i ? bus.middle_word_i : m_mid;
            m_req  = bus.upper_we_i && (bus.lower_we_i || m_lo_v) && (bus.middle_we_i || m_mid_v);
            m_drop = m_req && mq.size() == DEPTH && !m_pop;
`ifdef INSTR_FIFO_ERR_EN
            if (m_drop) m_ov = 1; else if (bus.err_clear_i) m_ov = 0;
            if (bus.upper_we_i && !m_req) m_se = 1; else if (bus.err_clear_i) m_se = 0;
`endif
            if (m_pop) void'(mq.pop_front());
            if (m_req && !m_drop) mq.push_back({bus.upper_word_i, m_m, m_l});
            if (bus.lower_we_i) m_lo = bus.lower_word_i;
            if (bus.middle_we_i) m_mid = bus.middle_word_i;
            m_lo_v  = !bus.upper_we_i && (m_lo_v || bus.lower_we_i);
            m_mid_v = !bus.upper_we_i && (m_mid_v || bus.middle_we_i);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid", 80'(bus.instr_valid_o), 80'(mq.size() > 0));
            chk("count", 80'(bus.count_o), 80'(mq.size()));
            chk("full", 80'(bus.full_o), 80'(mq.size() == DEPTH));
            chk("empty", 80'(bus.empty_o), 80'(mq.size() == 0));
            chk("instr", bus.instr_o, mq.size() > 0 ? mq[0] : 80'h0);
`ifdef INSTR_FIFO_ERR_EN
            chk("overflow", 80'(bus.overflow_o), 80'(m_ov));
            chk("seq_err", 80'(bus.seq_err_o), 80'(m_se));
`endif
        end
    end

    task automatic cyc(input logic [31:0] lw, input logic [31:0] mw, input logic [15:0] uw,
                       input logic l, input logic m, input logic u, input logic r);
        @(posedge clk);
        #1;
        bus.lower_word_i = lw; bus.middle_word_i = mw; bus.upper_word_i = uw;
        bus.lower_we_i = l; bus.middle_we_i = m; bus.upper_we_i = u; bus.instr_ready_i = r;
    endtask

    task automatic idle(input logic r);
        cyc(0, 0, 0, 0, 0, 0, r);
    endtask

    task automatic fill(input int n, input int base);
        for (int i = 0; i < n; i++) cyc(32'(base + i), 32'h5500_0000 + 32'(i), 16'(i), 1, 1, 1, 0);
    endtask

    task automatic clear_errs;
`ifdef INSTR_FIFO_ERR_EN
        @(posedge clk); #1 bus.err_clear_i = 1;
        @(posedge clk); #1 bus.err_clear_i = 0;
`endif
    endtask

    initial begin
        bus.lower_word_i = 0; bus.middle_word_i = 0; bus.upper_word_i = 0;
        bus.lower_we_i = 0; bus.middle_we_i = 0; bus.upper_we_i = 0; bus.instr_ready_i = 0;
`ifdef INSTR_FIFO_ERR_EN
        bus.err_clear_i = 0;
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("rst_valid", 80'(bus.instr_valid_o), 80'h0);
        chk("rst_empty", 80'(bus.empty_o), 80'h1);
        chk("rst_count", 80'(bus.count_o), 80'h0);
        chk("rst_instr", bus.instr_o, 80'h0);

        // Three separate beats.
        cyc(32'hCAFE0102, 0, 0, 1, 0, 0, 0);
        cyc(0, 32'h00ABCD00, 0, 0, 1, 0, 0);
        cyc(0, 0, 16'h1234, 0, 0, 1, 0);
        idle(0);
        @(negedge clk);
        chk("beats_valid", 80'(bus.instr_valid_o), 80'h1);
        chk("beats_opcode", 80'(bus.instr_o.opcode), 80'h02);
        chk("beats_length", 80'(bus.instr_o.length), 80'h00CAFE01);
        chk("beats_acc", 80'(bus.instr_o.acc_addr), 80'hABCD);
        chk("beats_buf", 80'(bus.instr_o.buffer_addr), 80'h123400);
        idle(1);
        idle(0);

        // All three enables in one cycle.
        cyc(32'h11223344, 32'h55667788, 16'h99AA, 1, 1, 1, 0);
        idle(0);
        @(negedge clk);
        chk("bypass_count", 80'(bus.count_o), 80'h1);
        chk("bypass_opcode", 80'(bus.instr_o.opcode), 80'h44);
        chk("bypass_buf", 80'(bus.instr_o.buffer_addr), 80'h99AA55);
        idle(1);
        idle(0);

        // Fill to full, overflow, then drain in order.
        fill(16, 0);
        idle(0);
        @(negedge clk);
        chk("fill_full", 80'(bus.full_o), 80'h1);
        chk("fill_count", 80'(bus.count_o), 80'd16);
        cyc(32'h000000EE, 0, 0, 1, 1, 1, 0);
        idle(0);
        @(negedge clk);
        chk("drop_count", 80'(bus.count_o), 80'd16);
`ifdef INSTR_FIFO_ERR_EN
        chk("drop_overflow", 80'(bus.overflow_o), 80'h1);
`endif
        clear_errs();
        for (int i = 0; i < 16; i++) begin
            idle(1);
            @(negedge clk);
            chk("drain_opcode", 80'(bus.instr_o.opcode), 80'(i));
        end
        idle(0);
        @(negedge clk);
        chk("drain_empty", 80'(bus.empty_o), 80'h1);

        // Push with pop at full, then a long wrapping stream.
        fill(16, 32);
        cyc(32'h000000C8, 0, 0, 1, 1, 1, 1);
        idle(0);
        @(negedge clk);
        chk("fullpp_count", 80'(bus.count_o), 80'd16);
        for (int k = 0; k < 40; k++) cyc(32'(100 + k), 32'(k), 16'(k), 1, 1, 1, 1);
        repeat (17) idle(1);
        idle(0);
        @(negedge clk);
        chk("wrap_empty", 80'(bus.empty_o), 80'h1);

        // Commit missing the lower beat.
        cyc(0, 32'hDEAD0000, 0, 0, 1, 0, 0);
        cyc(0, 0, 16'hBEEF, 0, 0, 1, 0);
        idle(0);
        @(negedge clk);
        chk("seq_count", 80'(bus.count_o), 80'h0);
`ifdef INSTR_FIFO_ERR_EN
        chk("seq_flag", 80'(bus.seq_err_o), 80'h1);
        clear_errs();
        @(negedge clk);
        chk("clr_seq", 80'(bus.seq_err_o), 80'h0);
        chk("clr_ovf", 80'(bus.overflow_o), 80'h0);
`endif

        // Asynchronous reset mid-cycle with entries and a pending lower beat.
        fill(5, 64);
        cyc(32'h77777777, 0, 0, 1, 0, 0, 0);
        @(posedge clk);
        #3 rst_n = 0;
        bus.lower_we_i = 0; bus.middle_we_i = 0; bus.upper_we_i = 0; bus.instr_ready_i = 0;
        #1;
        chk("arst_valid", 80'(bus.instr_valid_o), 80'h0);
        chk("arst_empty", 80'(bus.empty_o), 80'h1);
        chk("arst_count", 80'(bus.count_o), 80'h0);
        @(posedge clk);
        #1 rst_n = 1;
        cyc(0, 0, 16'h4242, 0, 0, 1, 0);
        idle(0);
        @(negedge clk);
        chk("post_rst_count", 80'(bus.count_o), 80'h0);
        idle(0);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
